// File: rtl/des_region_sweeper.sv
// des_region_sweeper
// Walks a CPU-programmed range of regions and, for each one, runs the
// des_block_wrapper command sequence: set region, start, wait for done,
// read the counter. Every {region, counter} result goes into a small
// first-word-fall-through FIFO that the CPU register interface drains.
module des_region_sweeper #(
    parameter int REGION_W   = 16,
    parameter int COUNT_W    = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REGION_W-1:0]           cfg_first,
    input  logic [REGION_W-1:0]           cfg_last,
    input  logic                          sweep_start,
    input  logic                          sweep_abort,
    output logic                          busy,
    output logic                          sweep_done,
    output logic                          cfg_err,
    output logic [1:0]                    des_cmd,
    output logic                          des_cmd_valid,
    output logic [REGION_W-1:0]           des_data,
    input  logic                          des_cmd_read,
    input  logic                          des_done,
    input  logic [COUNT_W-1:0]            des_counter,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [REGION_W-1:0]           res_region,
    output logic [COUNT_W-1:0]            res_counter,
    output logic [$clog2(FIFO_DEPTH):0]   res_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = REGION_W + COUNT_W;

    localparam logic [1:0] CMD_READ_REGION = 2'd0;
    localparam logic [1:0] CMD_START       = 2'd1;
    localparam logic [1:0] CMD_OUTPUT_READ = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SPACE,
        ST_SET_REGION,
        ST_START,
        ST_WAIT_DONE,
        ST_READ_OUT,
        ST_NEXT
    } state_e;

    state_e                state_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  cfg_err_reg;
    logic                  abort_reg;
    logic [1:0]            cmd_reg;
    logic                  valid_reg;
    logic [REGION_W-1:0]   data_reg;
    logic [REGION_W-1:0]   cur_reg;
    logic [REGION_W-1:0]   last_reg;

    // FIFO state
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_next;
    logic [CNT_W-1:0]      count_reg;
    logic [CNT_W-1:0]      count_next;
    logic [ENTRY_W-1:0]    entry_bus [FIFO_DEPTH];
    logic [ENTRY_W-1:0]    head_entry;
    logic [ENTRY_W-1:0]    push_data;

    logic                  fifo_full;
    logic                  fifo_has_space;
    logic                  pop_en;
    logic                  push_en;
    logic                  push_ok;

    assign fifo_full      = (count_reg == CNT_W'(FIFO_DEPTH));
    assign pop_en         = res_ready && (count_reg != '0);
    // A pop in the same cycle frees a slot, so a full FIFO being drained
    // does not cost the sweep an extra stall cycle.
    assign fifo_has_space = !fifo_full || pop_en;

    // The result is captured at the exact cycle the wrapper consumes OUTPUT_READ.
    assign push_en   = (state_reg == ST_READ_OUT) && valid_reg && des_cmd_read && des_done;
    assign push_ok   = push_en && (!fifo_full || pop_en);
    assign push_data = {cur_reg, des_counter};

    // Sweep sequencer: one wrapper command in flight at a time, outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            cfg_err_reg <= 1'b0;
            abort_reg   <= 1'b0;
            cmd_reg     <= CMD_READ_REGION;
            valid_reg   <= 1'b0;
            data_reg    <= '0;
            cur_reg     <= '0;
            last_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            // An abort only requests a stop; the region underway must finish
            // because the wrapper cannot cancel a search.
            if (busy_reg && sweep_abort) begin
                abort_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (sweep_start) begin
                        last_reg    <= cfg_last;
                        cur_reg     <= cfg_first;
                        abort_reg   <= 1'b0;
                        cfg_err_reg <= (cfg_last < cfg_first);
                        if (cfg_last < cfg_first) begin
                            done_reg <= 1'b1;
                        end else begin
                            busy_reg  <= 1'b1;
                            state_reg <= ST_WAIT_SPACE;
                        end
                    end
                end

                ST_WAIT_SPACE: begin
                    // Only place the sweep ever stalls, so a full FIFO never
                    // leaves the wrapper holding a half-finished handshake.
                    if (abort_reg || sweep_abort) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        abort_reg <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (fifo_has_space) begin
                        state_reg <= ST_SET_REGION;
                    end
                end

                ST_SET_REGION: begin
                    if (!valid_reg) begin
                        valid_reg <= 1'b1;
                        cmd_reg   <= CMD_READ_REGION;
                        data_reg  <= cur_reg;
                    end else if (des_cmd_read) begin
                        valid_reg <= 1'b0;
                        state_reg <= ST_START;
                    end
                end

                ST_START: begin
                    if (!valid_reg) begin
                        valid_reg <= 1'b1;
                        cmd_reg   <= CMD_START;
                    end else if (des_cmd_read) begin
                        valid_reg <= 1'b0;
                        state_reg <= ST_WAIT_DONE;
                    end
                end

                ST_WAIT_DONE: begin
                    if (des_done) begin
                        state_reg <= ST_READ_OUT;
                    end
                end

                ST_READ_OUT: begin
                    if (!valid_reg) begin
                        valid_reg <= 1'b1;
                        cmd_reg   <= CMD_OUTPUT_READ;
                    end else if (des_cmd_read && des_done) begin
                        valid_reg <= 1'b0;
                        state_reg <= ST_NEXT;
                    end
                end

                ST_NEXT: begin
                    // Compare before incrementing so a range ending at the top
                    // region terminates instead of wrapping to zero.
                    if (abort_reg || (cur_reg == last_reg)) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        abort_reg <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        cur_reg   <= cur_reg + REGION_W'(1);
                        state_reg <= ST_WAIT_SPACE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointer and occupancy update for push, pop, or both together
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop_en) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        case ({push_ok, pop_en})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // One storage register per FIFO slot, written when the write pointer selects it
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [ENTRY_W-1:0] entry_reg;

            // Slot capture on push
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= push_data;
                end
            end

            assign entry_bus[gi] = entry_reg;
        end
    endgenerate

    // Head is presented directly so the CPU sees data as soon as res_valid rises.
    assign head_entry = entry_bus[rd_ptr_reg];

    assign busy          = busy_reg;
    assign sweep_done    = done_reg;
    assign cfg_err       = cfg_err_reg;
    assign des_cmd       = cmd_reg;
    assign des_cmd_valid = valid_reg;
    assign des_data      = data_reg;
    assign res_valid     = (count_reg != '0);
    assign res_region    = head_entry[ENTRY_W-1:COUNT_W];
    assign res_counter   = head_entry[COUNT_W-1:0];
    assign res_count     = count_reg;

endmodule

// File: tb/tb_des_region_sweeper.sv
// tb_des_region_sweeper
// Drives region sweeps into des_region_sweeper against a behavioural model
// of des_block_wrapper, and checks every FIFO pop against a scoreboard of
// expected {region, counter} pairs filled when each sweep is launched.
`timescale 1ns/1ps
module tb_des_region_sweeper;

    localparam int REGION_W   = 16;
    localparam int COUNT_W    = 64;
    localparam int FIFO_DEPTH = 2;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [REGION_W-1:0] region;
        logic [COUNT_W-1:0]  counter;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [REGION_W-1:0] cfg_first;
    logic [REGION_W-1:0] cfg_last;
    logic                sweep_start;
    logic                sweep_abort;
    logic                busy;
    logic                sweep_done;
    logic                cfg_err;
    logic [1:0]          des_cmd;
    logic                des_cmd_valid;
    logic [REGION_W-1:0] des_data;
    logic                des_cmd_read;
    logic                des_done;
    logic [COUNT_W-1:0]  des_counter;
    logic                res_valid;
    logic                res_ready;
    logic [REGION_W-1:0] res_region;
    logic [COUNT_W-1:0]  res_counter;
    logic [CW-1:0]       res_count;

    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   valid_cycles = 0;
    exp_t sb_q[$];

    // wrapper model state
    logic [REGION_W-1:0] m_region;
    logic                m_searching;
    logic                m_clear;
    int                  m_count;

    always #5 clk = ~clk;

    des_region_sweeper #(
        .REGION_W   (REGION_W),
        .COUNT_W    (COUNT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_first     (cfg_first),
        .cfg_last      (cfg_last),
        .sweep_start   (sweep_start),
        .sweep_abort   (sweep_abort),
        .busy          (busy),
        .sweep_done    (sweep_done),
        .cfg_err       (cfg_err),
        .des_cmd       (des_cmd),
        .des_cmd_valid (des_cmd_valid),
        .des_data      (des_data),
        .des_cmd_read  (des_cmd_read),
        .des_done      (des_done),
        .des_counter   (des_counter),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_region    (res_region),
        .res_counter   (res_counter),
        .res_count     (res_count)
    );

    function automatic logic [COUNT_W-1:0] cnt_of(input logic [REGION_W-1:0] r);
        return {16'hC0DE, r, ~r, r ^ 16'h5A5A};
    endfunction

    task automatic check_val(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [REGION_W-1:0] r);
        exp_t e;
        e.region  = r;
        e.counter = cnt_of(r);
        sb_q.push_back(e);
    endtask

    task automatic start_sweep(input logic [REGION_W-1:0] f, input logic [REGION_W-1:0] l);
        @(posedge clk);
        #2;
        cfg_first   = f;
        cfg_last    = l;
        sweep_start = 1'b1;
        @(posedge clk);
        #2;
        sweep_start = 1'b0;
        $display("start sweep first=%h last=%h", f, l);
    endtask

    // Wait for one sweep_done, let the scoreboard drain, confirm it fired once.
    task automatic wait_sweep_done(input int budget, input string tag, input int base);
        int n;
        n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_done_seen"}, 80'(done_cnt - base), 80'd1);
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_sb_drained"}, 80'(sb_q.size()), 80'd0);
        repeat (20) @(negedge clk);
        check_val({tag, "_done_once"}, 80'(done_cnt - base), 80'd1);
        check_val({tag, "_busy_after"}, 80'(busy), 80'd0);
        check_val({tag, "_valid_after"}, 80'(des_cmd_valid), 80'd0);
    endtask

    // Behavioural des_block_wrapper: consumes a command one cycle after valid,
    // raises done a few cycles after START, drops it after OUTPUT_READ.
    initial begin
        des_cmd_read = 1'b0;
        des_done     = 1'b0;
        des_counter  = '0;
        m_region     = '0;
        m_searching  = 1'b0;
        m_clear      = 1'b0;
        m_count      = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                des_cmd_read = 1'b0;
                des_done     = 1'b0;
                m_searching  = 1'b0;
                m_clear      = 1'b0;
                m_count      = 0;
            end else begin
                if (des_cmd_valid) valid_cycles++;
                if (m_clear) begin
                    des_done = 1'b0;
                    m_clear  = 1'b0;
                end
                if (m_searching) begin
                    if (m_count == 0) begin
                        des_done    = 1'b1;
                        des_counter = cnt_of(m_region);
                        m_searching = 1'b0;
                    end else begin
                        m_count--;
                    end
                end
                if (des_cmd_valid && !des_cmd_read) begin
                    des_cmd_read = 1'b1;
                    case (des_cmd)
                        2'd0: m_region = des_data;
                        2'd1: begin
                            m_searching = 1'b1;
                            m_count     = 3 + int'(m_region % 4);
                        end
                        2'd2: m_clear = 1'b1;
                        default: ;
                    endcase
                end else begin
                    des_cmd_read = 1'b0;
                end
            end
        end
    end

    // Output monitor: counts sweep_done pulses and checks each pop
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sweep_done) done_cnt++;
                if (res_valid && res_ready) begin
                    check_val("pop_expected", 80'(res_valid), 80'(sb_q.size() != 0));
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        $display("pop region=%h counter=%h", res_region, res_counter);
                        check_val("pop_region", 80'(res_region), 80'(e.region));
                        check_val("pop_counter", 80'(res_counter), 80'(e.counter));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int vbase;
        int n;
        rst         = 1'b1;
        cfg_first   = '0;
        cfg_last    = '0;
        sweep_start = 1'b0;
        sweep_abort = 1'b0;
        res_ready   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", 80'(busy), 80'd0);
        check_val("rst_sweep_done", 80'(sweep_done), 80'd0);
        check_val("rst_cfg_err", 80'(cfg_err), 80'd0);
        check_val("rst_cmd_valid", 80'(des_cmd_valid), 80'd0);
        check_val("rst_cmd", 80'(des_cmd), 80'd0);
        check_val("rst_data", 80'(des_data), 80'd0);
        check_val("rst_res_valid", 80'(res_valid), 80'd0);
        check_val("rst_res_count", 80'(res_count), 80'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // cfg error: last < first
        vbase = valid_cycles;
        start_sweep(16'd3, 16'd2);
        @(negedge clk);
        check_val("t3_done_pulse", 80'(sweep_done), 80'd1);
        check_val("t3_cfg_err", 80'(cfg_err), 80'd1);
        check_val("t3_busy", 80'(busy), 80'd0);
        @(negedge clk);
        check_val("t3_done_cleared", 80'(sweep_done), 80'd0);
        repeat (10) @(negedge clk);
        check_val("t3_no_cmd", 80'(valid_cycles - vbase), 80'd0);
        check_val("t3_fifo_empty", 80'(res_count), 80'd0);
        check_val("t3_cfg_err_sticky", 80'(cfg_err), 80'd1);

        // normal sweep 5..7, with an ignored start while busy
        @(posedge clk);
        #2;
        res_ready = 1'b1;
        base = done_cnt;
        push_exp(16'd5);
        push_exp(16'd6);
        push_exp(16'd7);
        start_sweep(16'd5, 16'd7);
        @(negedge clk);
        check_val("t1_cfg_err_clear", 80'(cfg_err), 80'd0);
        check_val("t1_busy", 80'(busy), 80'd1);
        repeat (6) @(negedge clk);
        start_sweep(16'd0, 16'd0);
        @(negedge clk);
        check_val("t1_busy_after_restart", 80'(busy), 80'd1);
        wait_sweep_done(300, "t1", base);

        // top region, single entry, no wrap
        base = done_cnt;
        push_exp(16'hFFFF);
        start_sweep(16'hFFFF, 16'hFFFF);
        wait_sweep_done(200, "t2", base);
        check_val("t2_fifo_empty", 80'(res_count), 80'd0);

        // abort while idle must not affect the next sweep
        @(posedge clk);
        #2;
        sweep_abort = 1'b1;
        @(posedge clk);
        #2;
        sweep_abort = 1'b0;

        // backpressure: FIFO of 2 stalls the sweep
        res_ready = 1'b0;
        base = done_cnt;
        for (int r = 0; r <= 4; r++) push_exp(16'(r));
        start_sweep(16'd0, 16'd4);
        repeat (120) @(negedge clk);
        check_val("t4_stall_count", 80'(res_count), 80'd2);
        check_val("t4_stall_busy", 80'(busy), 80'd1);
        check_val("t4_stall_no_cmd", 80'(des_cmd_valid), 80'd0);
        check_val("t4_stall_head", 80'(res_region), 80'd0);
        @(posedge clk);
        #2;
        res_ready = 1'b1;
        wait_sweep_done(400, "t4", base);

        // abort during region 2 search
        base = done_cnt;
        for (int r = 0; r <= 2; r++) push_exp(16'(r));
        start_sweep(16'd0, 16'd9);
        n = 0;
        while (!(m_searching && m_region == 16'd2) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val("t5_reach_r2", 80'(m_searching && m_region == 16'd2), 80'd1);
        @(posedge clk);
        #2;
        sweep_abort = 1'b1;
        @(posedge clk);
        #2;
        sweep_abort = 1'b0;
        wait_sweep_done(300, "t5", base);

        // reset during START, then a 1..1 sweep
        start_sweep(16'd3, 16'd5);
        n = 0;
        while (!(des_cmd_valid && des_cmd == 2'd1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("t6_reach_start", 80'(des_cmd_valid && des_cmd == 2'd1), 80'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("t6_rst_cmd_valid", 80'(des_cmd_valid), 80'd0);
        check_val("t6_rst_busy", 80'(busy), 80'd0);
        check_val("t6_rst_res_valid", 80'(res_valid), 80'd0);
        check_val("t6_rst_res_count", 80'(res_count), 80'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        base = done_cnt;
        push_exp(16'd1);
        start_sweep(16'd1, 16'd1);
        wait_sweep_done(200, "t6", base);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
